// File: rtl/speicher_arbiter_pkg.sv
// Shared definitions for the two-requester RAM arbiter: FSM states and requester IDs.
package speicher_arbiter_pkg;

    typedef enum logic [1:0] {
        RUHE     = 2'd0,
        ZUGRIFF  = 2'd1,
        FREIGABE = 2'd2
    } zustand_e;

    localparam logic ANF_A = 1'b0;
    localparam logic ANF_B = 1'b1;

endpackage

// File: rtl/speicher_arbiter_rr_auswahl.sv
// Combinational round-robin picker for two requesters; on a tie the one
// that was not served last wins.
module speicher_arbiter_rr_auswahl
    import speicher_arbiter_pkg::*;
(
    input  logic anf_a_i,
    input  logic anf_b_i,
    input  logic zuletzt_i,
    output logic gnt_gueltig_o,
    output logic gnt_id_o
);

    // Pick the granted requester from the request bits and the last-served ID
    always_comb begin
        gnt_gueltig_o = anf_a_i | anf_b_i;
        gnt_id_o      = ANF_A;
        if (anf_a_i && anf_b_i) begin
            if (zuletzt_i == ANF_A) begin
                gnt_id_o = ANF_B;
            end else begin
                gnt_id_o = ANF_A;
            end
        end else if (anf_b_i) begin
            gnt_id_o = ANF_B;
        end else begin
            gnt_id_o = ANF_A;
        end
    end

endmodule

// File: rtl/speicher_arbiter.sv
// Shares one single-ported RAM between requesters A and B, one access at a time.
// Optional access timeout with Fehler pulse: define SPEICHER_ARBITER_TIMEOUT_EN.
module speicher_arbiter
    import speicher_arbiter_pkg::*;
#(
    parameter int ADRESSBREITE   = 32,
    parameter int WORTBREITE     = 32,
    parameter int TIMEOUT_ZYKLEN = 16
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    LeseA,
    input  logic                    SchreibeA,
    input  logic [ADRESSBREITE-1:0] AdresseA,
    input  logic [WORTBREITE-1:0]   DatenReinA,
    output logic [WORTBREITE-1:0]   DatenRausA,
    output logic                    GeladenA,
    output logic                    GespeichertA,
    input  logic                    LeseB,
    input  logic                    SchreibeB,
    input  logic [ADRESSBREITE-1:0] AdresseB,
    input  logic [WORTBREITE-1:0]   DatenReinB,
    output logic [WORTBREITE-1:0]   DatenRausB,
    output logic                    GeladenB,
    output logic                    GespeichertB,
    output logic                    RAMLesenAn,
    output logic                    RAMSchreibenAn,
    output logic [ADRESSBREITE-1:0] RAMAdresse,
    output logic [WORTBREITE-1:0]   RAMDatenRein,
    input  logic [WORTBREITE-1:0]   RAMDatenRaus,
    input  logic                    RAMDatenBereit,
    input  logic                    RAMDatenGeschrieben,
    output logic                    Fehler,
    output logic                    Belegt
);

    zustand_e                zustand_q, zustand_d;
    logic                    id_q, id_d;
    logic                    wr_q, wr_d;
    logic                    zuletzt_q, zuletzt_d;
    logic [ADRESSBREITE-1:0] adr_q, adr_d;
    logic [WORTBREITE-1:0]   wdat_q, wdat_d;
    logic [WORTBREITE-1:0]   raus_a_q, raus_a_d, raus_b_q, raus_b_d;
    logic                    geladen_a_q, geladen_a_d, gesp_a_q, gesp_a_d;
    logic                    geladen_b_q, geladen_b_d, gesp_b_q, gesp_b_d;
    logic                    gnt_gueltig_s, gnt_id_s;
    logic                    done_s, fertig_s, abbruch_s;

`ifdef SPEICHER_ARBITER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_ZYKLEN + 1);
    logic [TO_W-1:0] zaehler_q, zaehler_d;
    logic            fehler_q;
`else
    logic [31:0]     unused_timeout_s;
    assign unused_timeout_s = 32'(TIMEOUT_ZYKLEN);
`endif

    speicher_arbiter_rr_auswahl u_rr_auswahl (
        .anf_a_i       (LeseA | SchreibeA),
        .anf_b_i       (LeseB | SchreibeB),
        .zuletzt_i     (zuletzt_q),
        .gnt_gueltig_o (gnt_gueltig_s),
        .gnt_id_o      (gnt_id_s)
    );

    // Next-state, request latching and ack generation
    always_comb begin
        zustand_d   = zustand_q;
        id_d        = id_q;
        wr_d        = wr_q;
        zuletzt_d   = zuletzt_q;
        adr_d       = adr_q;
        wdat_d      = wdat_q;
        raus_a_d    = raus_a_q;
        raus_b_d    = raus_b_q;
        geladen_a_d = 1'b0;
        gesp_a_d    = 1'b0;
        geladen_b_d = 1'b0;
        gesp_b_d    = 1'b0;
        fertig_s    = 1'b0;
        abbruch_s   = 1'b0;
`ifdef SPEICHER_ARBITER_TIMEOUT_EN
        zaehler_d   = zaehler_q;
`endif
        // Only the done signal matching the latched op counts
        done_s      = wr_q ? RAMDatenGeschrieben : RAMDatenBereit;
        case (zustand_q)
            RUHE: begin
                if (gnt_gueltig_s) begin
                    zustand_d = ZUGRIFF;
                    id_d      = gnt_id_s;
                    if (gnt_id_s == ANF_A) begin
                        adr_d  = AdresseA;
                        wdat_d = DatenReinA;
                        wr_d   = SchreibeA;
                    end else begin
                        adr_d  = AdresseB;
                        wdat_d = DatenReinB;
                        wr_d   = SchreibeB;
                    end
`ifdef SPEICHER_ARBITER_TIMEOUT_EN
                    zaehler_d = {TO_W{1'b0}};
`endif
                end else begin
                    zustand_d = RUHE;
                end
            end
            ZUGRIFF: begin
                if (done_s) begin
                    fertig_s = 1'b1;
                end
`ifdef SPEICHER_ARBITER_TIMEOUT_EN
                else if (zaehler_q == TO_W'(TIMEOUT_ZYKLEN - 1)) begin
                    abbruch_s = 1'b1;
                end else begin
                    zaehler_d = zaehler_q + TO_W'(1);
                end
`else
                else begin
                    fertig_s = 1'b0;
                end
`endif
                if (fertig_s || abbruch_s) begin
                    zustand_d = FREIGABE;
                    zuletzt_d = id_q;
                    if (wr_q) begin
                        if (id_q == ANF_A) begin
                            gesp_a_d = 1'b1;
                        end else begin
                            gesp_b_d = 1'b1;
                        end
                    end else begin
                        if (id_q == ANF_A) begin
                            geladen_a_d = 1'b1;
                            raus_a_d    = abbruch_s ? {WORTBREITE{1'b0}} : RAMDatenRaus;
                        end else begin
                            geladen_b_d = 1'b1;
                            raus_b_d    = abbruch_s ? {WORTBREITE{1'b0}} : RAMDatenRaus;
                        end
                    end
                end else begin
                    zustand_d = ZUGRIFF;
                end
            end
            FREIGABE: begin
                zustand_d = RUHE;
            end
            default: begin
                zustand_d = RUHE;
            end
        endcase
    end

    // State, latched request and output registers
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            zustand_q   <= RUHE;
            id_q        <= ANF_A;
            wr_q        <= 1'b0;
            zuletzt_q   <= ANF_B;
            adr_q       <= {ADRESSBREITE{1'b0}};
            wdat_q      <= {WORTBREITE{1'b0}};
            raus_a_q    <= {WORTBREITE{1'b0}};
            raus_b_q    <= {WORTBREITE{1'b0}};
            geladen_a_q <= 1'b0;
            gesp_a_q    <= 1'b0;
            geladen_b_q <= 1'b0;
            gesp_b_q    <= 1'b0;
        end else begin
            zustand_q   <= zustand_d;
            id_q        <= id_d;
            wr_q        <= wr_d;
            zuletzt_q   <= zuletzt_d;
            adr_q       <= adr_d;
            wdat_q      <= wdat_d;
            raus_a_q    <= raus_a_d;
            raus_b_q    <= raus_b_d;
            geladen_a_q <= geladen_a_d;
            gesp_a_q    <= gesp_a_d;
            geladen_b_q <= geladen_b_d;
            gesp_b_q    <= gesp_b_d;
        end
    end

`ifdef SPEICHER_ARBITER_TIMEOUT_EN
    // Timeout counter and error pulse
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            zaehler_q <= {TO_W{1'b0}};
            fehler_q  <= 1'b0;
        end else begin
            zaehler_q <= zaehler_d;
            fehler_q  <= abbruch_s;
        end
    end

    assign Fehler = fehler_q;
`else
    assign Fehler = 1'b0;
`endif

    assign RAMLesenAn     = (zustand_q == ZUGRIFF) && !wr_q;
    assign RAMSchreibenAn = (zustand_q == ZUGRIFF) && wr_q;
    assign RAMAdresse     = adr_q;
    assign RAMDatenRein   = wdat_q;
    assign DatenRausA     = raus_a_q;
    assign DatenRausB     = raus_b_q;
    assign GeladenA       = geladen_a_q;
    assign GespeichertA   = gesp_a_q;
    assign GeladenB       = geladen_b_q;
    assign GespeichertB   = gesp_b_q;
    assign Belegt         = (zustand_q != RUHE);

endmodule

// File: tb/tb_speicher_arbiter.sv
// Self-checking bench for speicher_arbiter: directed scenarios plus randomized
// two-requester traffic against a transaction-level reference model and RAM model.
module tb_speicher_arbiter;

    logic        Clock, Reset;
    logic        LeseA, SchreibeA, LeseB, SchreibeB;
    logic [31:0] AdresseA, DatenReinA, DatenRausA, AdresseB, DatenReinB, DatenRausB;
    logic        GeladenA, GespeichertA, GeladenB, GespeichertB;
    logic        RAMLesenAn, RAMSchreibenAn, RAMDatenBereit, RAMDatenGeschrieben;
    logic [31:0] RAMAdresse, RAMDatenRein, RAMDatenRaus;
    logic        Fehler, Belegt;

    speicher_arbiter #(.ADRESSBREITE(32), .WORTBREITE(32), .TIMEOUT_ZYKLEN(16)) dut (
        .Clock(Clock), .Reset(Reset),
        .LeseA(LeseA), .SchreibeA(SchreibeA), .AdresseA(AdresseA), .DatenReinA(DatenReinA),
        .DatenRausA(DatenRausA), .GeladenA(GeladenA), .GespeichertA(GespeichertA),
        .LeseB(LeseB), .SchreibeB(SchreibeB), .AdresseB(AdresseB), .DatenReinB(DatenReinB),
        .DatenRausB(DatenRausB), .GeladenB(GeladenB), .GespeichertB(GespeichertB),
        .RAMLesenAn(RAMLesenAn), .RAMSchreibenAn(RAMSchreibenAn), .RAMAdresse(RAMAdresse),
        .RAMDatenRein(RAMDatenRein), .RAMDatenRaus(RAMDatenRaus),
        .RAMDatenBereit(RAMDatenBereit), .RAMDatenGeschrieben(RAMDatenGeschrieben),
        .Fehler(Fehler), .Belegt(Belegt)
    );

    int n_vec = 0;
    int n_err = 0;

    // RAM model state and reference memory
    logic [31:0] ram_mem [64];
    logic [31:0] ref_mem [64];
    int          ram_lat      = 2;
    bit          ram_mute     = 1'b0;
    bit          expect_abort = 1'b0;
    int          lat_cnt, lat_cur;

    // Outstanding transaction per requester (0 = A, 1 = B)
    logic [31:0] exp_adr [2];
    logic [31:0] exp_dat [2];
    bit          exp_wr  [2];
    logic [31:0] exp_dout[2];
    int          last_wait[2];
    int unsigned ack_log[$];

    // Monitor state
    bit          last_who, who, is_wr, both_req, solo_who;
    bit          strobe, p_strobe, p_ack, p_req_a, p_req_b, acc_wr;
    logic [3:0]  ack_v;
    logic [31:0] acc_adr, acc_dat;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h, expected %h", tag, got, exp);
        end
    endtask

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    // RAM model: answers after ram_lat strobe cycles (random 1..4 when 0), may emit stray done
    initial begin
        lat_cnt = 0;
        lat_cur = 1;
        forever begin
            @(negedge Clock);
            RAMDatenBereit      = 1'b0;
            RAMDatenGeschrieben = 1'b0;
            RAMDatenRaus        = $urandom;
            if (RAMLesenAn || RAMSchreibenAn) begin
                if (lat_cnt == 0) lat_cur = (ram_lat == 0) ? int'($urandom_range(1, 4)) : ram_lat;
                lat_cnt++;
                if (!ram_mute && lat_cnt == lat_cur) begin
                    if (RAMSchreibenAn) begin
                        ram_mem[RAMAdresse[7:2]] = RAMDatenRein;
                        RAMDatenGeschrieben      = 1'b1;
                    end else begin
                        RAMDatenRaus   = ram_mem[RAMAdresse[7:2]];
                        RAMDatenBereit = 1'b1;
                    end
                end else if (ram_lat == 0 && $urandom_range(0, 3) == 0) begin
                    if (RAMSchreibenAn) RAMDatenBereit = 1'b1;
                    else                RAMDatenGeschrieben = 1'b1;
                end
            end else begin
                lat_cnt = 0;
            end
        end
    end

    // Transaction-level monitor: grant rule, routing, data and pulse shape
    initial begin
        forever begin
            @(negedge Clock);
            if (!Reset) begin
                last_who = 1'b1;
                exp_dout[0] = 32'h0;
                exp_dout[1] = 32'h0;
                p_strobe = 1'b0; p_ack = 1'b0; p_req_a = 1'b0; p_req_b = 1'b0;
            end else begin
                strobe = RAMLesenAn | RAMSchreibenAn;
                ack_v  = {GespeichertB, GeladenB, GespeichertA, GeladenA};
                chk("strobe_excl", 32'(RAMLesenAn & RAMSchreibenAn), 32'h0);
                chk("fehler", 32'(Fehler), 32'(expect_abort & (|ack_v)));
                if (strobe) chk("belegt_busy", 32'(Belegt), 32'h1);
                if (strobe && !p_strobe) begin
                    acc_adr  = RAMAdresse;
                    acc_dat  = RAMDatenRein;
                    acc_wr   = RAMSchreibenAn;
                    both_req = p_req_a & p_req_b;
                    solo_who = p_req_b & !p_req_a;
                end
                if (|ack_v) begin
                    who   = GeladenB | GespeichertB;
                    is_wr = GespeichertA | GespeichertB;
                    chk("ack_onehot", 32'($countones(ack_v)), 32'h1);
                    chk("ack_gap", 32'(strobe), 32'h0);
                    chk("ack_len", 32'(p_ack), 32'h0);
                    chk("grant_order", 32'(who), 32'(both_req ? !last_who : solo_who));
                    chk("ack_kind", 32'(is_wr), 32'(exp_wr[who]));
                    chk("ram_op", 32'(acc_wr), 32'(exp_wr[who]));
                    chk("ram_adr", acc_adr, exp_adr[who]);
                    if (is_wr) begin
                        chk("ram_wdat", acc_dat, exp_dat[who]);
                        if (!expect_abort) ref_mem[exp_adr[who][7:2]] = exp_dat[who];
                    end else begin
                        exp_dout[who] = expect_abort ? 32'h0 : ref_mem[exp_adr[who][7:2]];
                    end
                    chk("dout_a", DatenRausA, exp_dout[0]);
                    chk("dout_b", DatenRausB, exp_dout[1]);
                    last_who = who;
                    ack_log.push_back(32'(who));
                end
                p_strobe = strobe;
                p_ack    = |ack_v;
                p_req_a  = LeseA | SchreibeA;
                p_req_b  = LeseB | SchreibeB;
            end
        end
    end

    // One request: kind 0 read, 1 write, 2 read+write. Call and return at posedge+1.
    task automatic one_tx(input int w, input int kind, input logic [31:0] adr, input logic [31:0] dat);
        int n;
        bit got;
        exp_adr[w] = adr;
        exp_dat[w] = dat;
        exp_wr[w]  = (kind != 0);
        if (w == 0) begin
            LeseA = (kind != 1); SchreibeA = (kind != 0); AdresseA = adr; DatenReinA = dat;
        end else begin
            LeseB = (kind != 1); SchreibeB = (kind != 0); AdresseB = adr; DatenReinB = dat;
        end
        n   = 0;
        got = 1'b0;
        while (!got && n < 100) begin
            @(negedge Clock);
            n++;
            got = (w == 0) ? (GeladenA | GespeichertA) : (GeladenB | GespeichertB);
        end
        last_wait[w] = n;
        chk("ack_seen", 32'(got), 32'h1);
        @(posedge Clock); #1;
        if (w == 0) begin LeseA = 1'b0; SchreibeA = 1'b0; end
        else        begin LeseB = 1'b0; SchreibeB = 1'b0; end
    endtask

    task automatic requester(input int w, input int n, input int max_idle);
        logic [5:0] wi;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, max_idle)) begin @(posedge Clock); #1; end
            wi = 6'($urandom_range(0, 63));
            one_tx(w, int'($urandom_range(0, 2)), {24'h0, wi, 2'b00}, $urandom);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            ram_mem[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
            ref_mem[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
        end
        ram_mem[4] = 32'hDEAD_BEEF;
        ref_mem[4] = 32'hDEAD_BEEF;
        Reset = 1'b0;
        LeseA = 1'b0; SchreibeA = 1'b0; AdresseA = 32'h0; DatenReinA = 32'h0;
        LeseB = 1'b0; SchreibeB = 1'b0; AdresseB = 32'h0; DatenReinB = 32'h0;
        repeat (2) @(posedge Clock);
        #1;
        chk("rst_rd", 32'(RAMLesenAn), 32'h0);
        chk("rst_wr", 32'(RAMSchreibenAn), 32'h0);
        chk("rst_adr", RAMAdresse, 32'h0);
        chk("rst_wdat", RAMDatenRein, 32'h0);
        chk("rst_dout_a", DatenRausA, 32'h0);
        chk("rst_dout_b", DatenRausB, 32'h0);
        chk("rst_acks", 32'({GeladenA, GespeichertA, GeladenB, GespeichertB}), 32'h0);
        chk("rst_belegt", 32'(Belegt), 32'h0);
        chk("rst_fehler", 32'(Fehler), 32'h0);
        Reset = 1'b1;

        // Single read with 2-cycle RAM latency
        one_tx(0, 0, 32'h10, 32'h0);
        chk("rd_data", DatenRausA, 32'hDEAD_BEEF);
        chk("rd_latency", 32'(last_wait[0]), 32'd4);
        chk("rd_b_hold", DatenRausB, 32'h0);

        // Reset while an access is in flight
        ram_mute = 1'b1;
        LeseA = 1'b1; AdresseA = 32'h20;
        repeat (3) @(negedge Clock);
        chk("mid_strobe", 32'(RAMLesenAn), 32'h1);
        #2 Reset = 1'b0;
        #1;
        chk("mid_rst_strobe", 32'(RAMLesenAn), 32'h0);
        chk("mid_rst_belegt", 32'(Belegt), 32'h0);
        chk("mid_rst_adr", RAMAdresse, 32'h0);
        chk("mid_rst_dout", DatenRausA, 32'h0);
        LeseA = 1'b0;
        ram_mute = 1'b0;
        repeat (2) @(posedge Clock);
        #1 Reset = 1'b1;
        repeat (2) @(negedge Clock);
        chk("mid_no_ack", 32'(GeladenA), 32'h0);
        chk("mid_idle", 32'(Belegt), 32'h0);

        // Simultaneous requests right after reset: A first
        @(posedge Clock); #1;
        ack_log.delete();
        fork
            one_tx(0, 1, 32'h04, 32'h55);
            one_tx(1, 0, 32'h08, 32'h0);
        join
        chk("sim_count", 32'(ack_log.size()), 32'd2);
        chk("sim_first", (ack_log.size() > 0) ? ack_log[0] : 32'hFFFF, 32'd0);
        chk("sim_second", (ack_log.size() > 1) ? ack_log[1] : 32'hFFFF, 32'd1);
        chk("sim_ram_wr", ram_mem[1], 32'h55);

        // Continuous competition alternates strictly
        ack_log.delete();
        fork
            requester(0, 3, 0);
            requester(1, 3, 0);
        join
        chk("fair_count", 32'(ack_log.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            chk("fair_order", (ack_log.size() > i) ? ack_log[i] : 32'hFFFF, 32'(i % 2));

        // Read and write together: write wins
        one_tx(0, 2, 32'h30, 32'hA5A5_0F0F);
        chk("coll_ram", ram_mem[12], 32'hA5A5_0F0F);

        // Randomized traffic with random RAM latency and stray done pulses
        ram_lat = 0;
        fork
            requester(0, 25, 3);
            requester(1, 25, 3);
        join
        ram_lat = 2;

`ifdef SPEICHER_ARBITER_TIMEOUT_EN
        ram_mute     = 1'b1;
        expect_abort = 1'b1;
        one_tx(1, 0, 32'h40, 32'h0);
        chk("to_latency", 32'(last_wait[1]), 32'd18);
        chk("to_dout", DatenRausB, 32'h0);
        chk("to_belegt", 32'(Belegt), 32'h0);
        expect_abort = 1'b0;
        ram_mute     = 1'b0;
`endif

        repeat (2) @(posedge Clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
